// File: rtl/rv32_pkg.sv
// Shared pipeline constants and helpers for the RV32 hazard/forwarding logic.
// Pure definitions; no state, no latency, no flow control.
package rv32_pkg;

    // Architectural zero register: never a real producer, never forwarded.
    localparam int unsigned REG_X0 = 0;

    // Widest forwarding-stage vector the priority helper accepts.
    localparam int MAX_FWD = 32;

    // Index of the lowest set bit (the youngest stage); MAX_FWD when none set.
    function automatic int lowest_set(input logic [MAX_FWD-1:0] vec);
        int idx;
        idx = MAX_FWD;
        for (int k = MAX_FWD - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fwd_priority_sel.sv
// Youngest-match forwarding selector for a single source operand.
// Purely combinational (0 cycles); has no flow control of its own.
module fwd_priority_sel
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3
) (
    input  logic                      rd_en_i,
    input  logic [REG_AW-1:0]         rs_i,
    input  logic [NUM_FWD-1:0]        stg_valid_i,
    input  logic [NUM_FWD-1:0]        stg_wb_en_i,
    input  logic [NUM_FWD-1:0]        stg_ready_i,
    input  logic [NUM_FWD*REG_AW-1:0] stg_addr_i,
    input  logic [NUM_FWD*XLEN-1:0]   stg_data_i,
    output logic                      hit_o,
    output logic                      ready_o,
    output logic [XLEN-1:0]           data_o
);

    logic [MAX_FWD-1:0] match_vec;
    logic               rs_nonzero;
    int                 win;

    assign rs_nonzero = (rs_i != REG_AW'(REG_X0));

    always_comb begin
        match_vec = '0;
        for (int s = 0; s < NUM_FWD; s++) begin
            match_vec[s] = rd_en_i & rs_nonzero & stg_valid_i[s] & stg_wb_en_i[s]
                         & (stg_addr_i[s*REG_AW +: REG_AW] == rs_i);
        end
    end

    assign win   = lowest_set(match_vec);
    assign hit_o = (win != MAX_FWD);

    // Only the winning stage is looked at; older matches never leak through.
    always_comb begin
        ready_o = 1'b0;
        data_o  = '0;
        for (int s = 0; s < NUM_FWD; s++) begin
            if (win == s) begin
                ready_o = stg_ready_i[s];
                data_o  = stg_data_i[s*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// RAW hazard, forwarding and stall control between OF and EX/MEM/WB results.
// Forwarded operands are registered (1 cycle); stall is combinational and holds IF/OF.
module fwd_hazard_unit
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 3,
    parameter int MAX_LO  = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      of_valid,
    input  logic [NUM_SRC*REG_AW-1:0] of_rs_sel,
    input  logic [NUM_SRC-1:0]        of_rs_used,
    input  logic [NUM_FWD-1:0]        stg_valid,
    input  logic [NUM_FWD-1:0]        stg_wb_en,
    input  logic [NUM_FWD-1:0]        stg_ready,
    input  logic [NUM_FWD*REG_AW-1:0] stg_addr,
    input  logic [NUM_FWD*XLEN-1:0]   stg_data,
    input  logic                      lo_issue,
    input  logic [REG_AW-1:0]         lo_rd,
    input  logic                      lo_done,
    input  logic [REG_AW-1:0]         lo_done_rd,
    output logic [NUM_SRC*XLEN-1:0]   fwd_rs_data,
    output logic [NUM_SRC-1:0]        fwd_rs_enable,
    output logic                      stall,
    output logic                      lo_full
);

    localparam int NREG  = 2 ** REG_AW;
    localparam int CNT_W = $clog2(MAX_LO + 1);

    logic [NUM_SRC-1:0] src_hit;
    logic [NUM_SRC-1:0] src_rdy;
    logic [XLEN-1:0]    src_dat [NUM_SRC];

    logic [NUM_SRC*XLEN-1:0] fwd_data_q, fwd_data_d;
    logic [NUM_SRC-1:0]      fwd_en_q, fwd_en_d;
    logic [NREG-1:0]         busy_q, busy_d;
    logic [CNT_W-1:0]        lo_cnt_q, lo_cnt_d;

    logic load_use;
    logic sb_hit;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_priority_sel #(
            .XLEN    (XLEN),
            .REG_AW  (REG_AW),
            .NUM_FWD (NUM_FWD)
        ) u_sel (
            .rd_en_i     (of_valid & of_rs_used[g]),
            .rs_i        (of_rs_sel[g*REG_AW +: REG_AW]),
            .stg_valid_i (stg_valid),
            .stg_wb_en_i (stg_wb_en),
            .stg_ready_i (stg_ready),
            .stg_addr_i  (stg_addr),
            .stg_data_i  (stg_data),
            .hit_o       (src_hit[g]),
            .ready_o     (src_rdy[g]),
            .data_o      (src_dat[g])
        );
    end

    // Data keeps its last value when nothing usable matches; only enable drops.
    always_comb begin
        fwd_data_d = fwd_data_q;
        fwd_en_d   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_hit[i] && src_rdy[i]) begin
                fwd_en_d[i]                = 1'b1;
                fwd_data_d[i*XLEN +: XLEN] = src_dat[i];
            end
        end
    end

    // Clear first so a same-register issue in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (lo_done) begin
            busy_d[lo_done_rd] = 1'b0;
        end
        if (lo_issue && (lo_rd != REG_AW'(REG_X0))) begin
            busy_d[lo_rd] = 1'b1;
        end
    end

    assign lo_full = (lo_cnt_q == CNT_W'(MAX_LO));

    always_comb begin
        lo_cnt_d = lo_cnt_q;
        if (lo_issue && !lo_done && !lo_full) begin
            lo_cnt_d = lo_cnt_q + CNT_W'(1);
        end else if (lo_done && !lo_issue && (lo_cnt_q != '0)) begin
            lo_cnt_d = lo_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        load_use = 1'b0;
        sb_hit   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_hit[i] && !src_rdy[i]) begin
                load_use = 1'b1;
            end
            if (of_valid && of_rs_used[i] && busy_q[of_rs_sel[i*REG_AW +: REG_AW]]
                && !(src_hit[i] && src_rdy[i])) begin
                sb_hit = 1'b1;
            end
        end
    end

    assign stall = load_use | sb_hit | (lo_full & lo_issue);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fwd_data_q <= '0;
            fwd_en_q   <= '0;
            busy_q     <= '0;
            lo_cnt_q   <= '0;
        end else begin
            fwd_data_q <= fwd_data_d;
            fwd_en_q   <= fwd_en_d;
            busy_q     <= busy_d;
            lo_cnt_q   <= lo_cnt_d;
        end
    end

    assign fwd_rs_data   = fwd_data_q;
    assign fwd_rs_enable = fwd_en_q;

    // Caller protocol: never overflow or underflow the outstanding count.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(lo_issue && !lo_done && lo_full));
    a_no_done_when_empty: assert property (@(posedge clk) disable iff (!resetn)
        !(lo_done && !lo_issue && (lo_cnt_q == '0)));

endmodule
